bsg_front_side_bus_hop_in_fc: RTL and testbench
===============================================

// Module: bsg_front_side_bus_hop_in_fc
// PURPOSE
//  Flow-controlled front-side-bus hop-in stage: accepts one packet per cycle from the upstream hop,
//  buffers it in a small circular FIFO, and forks each entry to the downstream hop and to the
//  local node(s). An entry retires only once every required consumer has taken it.
//  Provides ready/valid backpressure to upstream.
// PARAMETERS
//  width_p    32  packet width in bits
//  els_p      2   FIFO depth in entries; power of 2, >=2
//  num_out_p  2   output channels; ch0 = next hop (always required), ch1..num_out_p-1 = local ports
// PORTS
//  clk_i           in   1                        clock
//  reset_i         in   1                        async active-high reset
//  data_i          in   width_p                  upstream packet
//  v_i             in   1                        upstream valid
//  ready_o         out  1                        upstream ready (= FIFO not full)
//  local_accept_i  in   num_out_p-1              per-local-port accept; sampled at enqueue
//  data_o          out  num_out_p*width_p        head packet replicated on every channel
//  v_o             out  num_out_p                per-channel valid
//  yumi_i          in   num_out_p                per-channel consume; legal only when v_o[i]
//  stall_cnt_o     out  16                       only with BSG_FSB_HOP_IN_STALL_CNT_EN
// BEHAVIOUR
//  - Clock clk_i; reset_i is asynchronous and active-high; all state clears on assertion, no clock needed.
//  - Reset values: ready_o=1, v_o=0, wr/rd ptrs=0, count=0, done bits=0, stall_cnt_o=0; data_o undefined.
//  - Enqueue: v_i & ready_o -> store {data_i, need}, wr_ptr+1 (mod els_p).
//    need[0]=1; need[i]=local_accept_i[i-1] for i>=1.
//  - ready_o = (count != els_p); registered from state, no combinational path from v_i or yumi_i.
//  - Latency: packet enqueued in cycle N is visible on data_o/v_o in cycle N+1 if FIFO was empty.
//  - v_o[i] = (count!=0) & need_head[i] & ~done[i]; data_o slice i = head data for all i.
//  - done[i] sets on yumi_i[i]. Head retires in the cycle where, for every i,
//    done[i] | yumi_i[i] | ~need_head[i]; on retire rd_ptr+1 and all done bits clear.
//  - Consumers may take the head in different cycles, in any order; v_o[i] drops the cycle after
//    its own yumi while others remain pending.
//  - Simultaneous enqueue+retire when full: not allowed (ready_o=0); when not full: count unchanged.
//  - Pointer wrap at els_p-1 -> 0; count in 0..els_p, width clog2(els_p+1).
//  - yumi_i[i] while v_o[i]=0: ignored, no state change (assertion flags it in simulation).
//  - Reset mid-packet: buffered entries and partial done state discarded; no output after release
//    until a new enqueue.
//  - Throughput: 1 packet/cycle sustained when all required consumers yumi in the cycle valid rises.
// CONFIGURATION
//  - BSG_FSB_HOP_IN_STALL_CNT_EN defined: port stall_cnt_o present; increments each cycle
//    v_i & ~ready_o; saturates at 16'hFFFF; cleared only by reset_i.
//  - Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  - Reset: assert reset_i without clock edge -> v_o=0, ready_o=1 immediately.
//  - Single packet 32'hDEADBEEF, local_accept_i=1, both yumi next cycle
//    -> v_o=2'b11 cycle N+1, data_o={2{32'hDEADBEEF}}, FIFO empty N+2.
//  - local_accept_i=0 at enqueue -> v_o=2'b01; yumi_i[0] alone retires head.
//  - Split consume: yumi_i=2'b01 at N+1, 2'b10 at N+3 -> v_o 11,10,10,00; retire at N+3.
//  - Hold yumi_i=0, drive v_i=1 for 4 cycles, els_p=2 -> ready_o=0 after 2 enqueues;
//    order A,B preserved; with macro stall_cnt_o=2.
//  - Back-to-back 8 packets, yumi_i=all-ones every cycle -> 1 packet/cycle, ready_o never drops,
//    wrap verified.

Source files
------------

// File: rtl/bsg_front_side_bus_hop_in_fc_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bsg_front_side_bus_hop_in_fc_if                                    |
// | Desc   : Upstream ready/valid + forked downstream/local channel bundle.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface bsg_front_side_bus_hop_in_fc_if #(
  parameter int width_p   = 32,
  parameter int num_out_p = 2
);
  logic [width_p-1:0]           data_i;
  logic                         v_i;
  logic                         ready_o;
  logic [num_out_p-2:0]         local_accept_i;
  logic [num_out_p*width_p-1:0] data_o;
  logic [num_out_p-1:0]         v_o;
  logic [num_out_p-1:0]         yumi_i;

  modport slave (
    input  data_i, v_i, local_accept_i, yumi_i,
    output ready_o, data_o, v_o
  );

  modport master (
    output data_i, v_i, local_accept_i, yumi_i,
    input  ready_o, data_o, v_o
  );
endinterface
`default_nettype wire

// File: rtl/bsg_front_side_bus_hop_in_fc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bsg_front_side_bus_hop_in_fc                                       |
// | Desc   : FSB hop-in FIFO forking each entry to next hop and local ports;    |
// |          optional stall counter under BSG_FSB_HOP_IN_STALL_CNT_EN.          |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module bsg_front_side_bus_hop_in_fc #(
  parameter int width_p   = 32,
  parameter int els_p     = 2,
  parameter int num_out_p = 2
) (
  input  wire logic                 clk_i,
  input  wire logic                 reset_i,
`ifdef BSG_FSB_HOP_IN_STALL_CNT_EN
  output logic [15:0]               stall_cnt_o,
`endif
  bsg_front_side_bus_hop_in_fc_if.slave bus
);

  localparam int c_ptr_w = $clog2(els_p);
  localparam int c_cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0]   r_data [els_p];
  logic [num_out_p-1:0] r_need [els_p];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic [num_out_p-1:0] r_done;

  logic                 w_nonempty;
  logic                 w_enq;
  logic                 w_retire;
  logic [num_out_p-1:0] w_need_in;
  logic [num_out_p-1:0] w_need_head;
  logic [num_out_p-1:0] w_v;
  logic [num_out_p-1:0] w_yumi_eff;

  assign w_nonempty  = (r_count != '0);
  assign bus.ready_o = (r_count != c_cnt_w'(els_p));
  assign w_enq       = bus.v_i & bus.ready_o;
  assign w_need_in   = {bus.local_accept_i, 1'b1};
  assign w_need_head = r_need[r_rd_ptr];
  assign w_v         = {num_out_p{w_nonempty}} & w_need_head & ~r_done;
  assign bus.v_o     = w_v;
  // A yumi on a channel that is not offering is dropped rather than recorded.
  assign w_yumi_eff  = bus.yumi_i & w_v;
  assign w_retire    = w_nonempty & (&(r_done | w_yumi_eff | ~w_need_head));

  for (genvar g = 0; g < num_out_p; g++) begin : g_rep
    assign bus.data_o[g*width_p +: width_p] = r_data[r_rd_ptr];
  end

  // Storage carries no reset: contents are only observed behind a valid count.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_data[r_wr_ptr] <= bus.data_i;
      r_need[r_wr_ptr] <= w_need_in;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_done   <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_retire) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        r_done   <= '0;
      end else begin
        r_done   <= r_done | w_yumi_eff;
      end
      r_count <= r_count + c_cnt_w'(w_enq) - c_cnt_w'(w_retire);
    end
  end

`ifdef BSG_FSB_HOP_IN_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_stall_cnt <= '0;
    end else if (bus.v_i && !bus.ready_o && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

  ap_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    ((bus.yumi_i & ~w_v) == '0));

endmodule
`default_nettype wire

// File: tb/tb_bsg_front_side_bus_hop_in_fc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_bsg_front_side_bus_hop_in_fc                                    |
// | Desc   : Directed + random bench against a queue-based reference model.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_bsg_front_side_bus_hop_in_fc;
  localparam int W   = 32;
  localparam int ELS = 2;
  localparam int N   = 2;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bsg_front_side_bus_hop_in_fc_if #(.width_p(W), .num_out_p(N)) bus ();

`ifdef BSG_FSB_HOP_IN_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  bsg_front_side_bus_hop_in_fc #(.width_p(W), .els_p(ELS), .num_out_p(N)) dut (
    .clk_i       (clk),
    .reset_i     (rst),
`ifdef BSG_FSB_HOP_IN_STALL_CNT_EN
    .stall_cnt_o (stall_cnt),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [N-1:0] need;
  } ent_t;

  ent_t         q[$];
  logic [N-1:0] mdone;
  int           mstall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_v();
    if (q.size() == 0) return '0;
    return q[0].need & ~mdone;
  endfunction

  task automatic model_reset();
    q.delete();
    mdone  = '0;
    mstall = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".v_o"}, 64'(bus.v_o), 64'(exp_v()));
    check({tag, ".ready_o"}, 64'(bus.ready_o), 64'(q.size() != ELS));
    if (q.size() != 0)
      check({tag, ".data_o"}, 64'(bus.data_o), 64'({N{q[0].d}}));
`ifdef BSG_FSB_HOP_IN_STALL_CNT_EN
    check({tag, ".stall"}, 64'(stall_cnt), 64'(mstall));
`endif
  endtask

  // One clock: drive inputs, advance the model across the edge, check outputs.
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] d,
                       input logic [N-2:0] la, input logic [N-1:0] y);
    logic [N-1:0] ye;
    logic         ret;
    logic         enq;
    bus.v_i            = v;
    bus.data_i         = d;
    bus.local_accept_i = la;
    bus.yumi_i         = y;
    ye  = y & exp_v();
    ret = (q.size() != 0) && (&(mdone | ye | ~q[0].need));
    enq = v && (q.size() != ELS);
    if (v && !enq && mstall < 65535) mstall++;
    @(posedge clk);
    #1;
    if (ret) begin
      void'(q.pop_front());
      mdone = '0;
    end else begin
      mdone = mdone | ye;
    end
    if (enq) q.push_back('{d: d, need: {la, 1'b1}});
    bus.v_i    = 1'b0;
    bus.yumi_i = '0;
    check_outputs(tag);
  endtask

  initial begin
    logic [N-1:0] y;
    bus.v_i            = 1'b0;
    bus.data_i         = '0;
    bus.local_accept_i = '0;
    bus.yumi_i         = '0;
    model_reset();

    // Reset takes effect with no clock edge.
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("reset.v_o", 64'(bus.v_o), 64'(0));
    check("reset.ready_o", 64'(bus.ready_o), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single packet to both consumers.
    cycle("single.enq", 1'b1, 32'hDEADBEEF, 1'b1, 2'b00);
    check("single.v11", 64'(bus.v_o), 64'h3);
    check("single.data", 64'(bus.data_o), {2{32'hDEADBEEF}});
    cycle("single.yumi", 1'b0, '0, 1'b0, 2'b11);
    check("single.empty", 64'(bus.v_o), 64'h0);

    // Local port declines: only next hop needed.
    cycle("noloc.enq", 1'b1, 32'h12345678, 1'b0, 2'b00);
    check("noloc.v01", 64'(bus.v_o), 64'h1);
    cycle("noloc.yumi0", 1'b0, '0, 1'b0, 2'b01);
    check("noloc.retired", 64'(bus.v_o), 64'h0);

    // Split consume in different cycles.
    cycle("split.enq", 1'b1, 32'hA5A5A5A5, 1'b1, 2'b00);
    check("split.v11", 64'(bus.v_o), 64'h3);
    cycle("split.y01", 1'b0, '0, 1'b0, 2'b01);
    check("split.v10a", 64'(bus.v_o), 64'h2);
    cycle("split.idle", 1'b0, '0, 1'b0, 2'b00);
    check("split.v10b", 64'(bus.v_o), 64'h2);
    cycle("split.y10", 1'b0, '0, 1'b0, 2'b10);
    check("split.v00", 64'(bus.v_o), 64'h0);

    // Fill with no consumption: backpressure and ordering.
    cycle("fill.A", 1'b1, 32'h0000000A, 1'b1, 2'b00);
    cycle("fill.B", 1'b1, 32'h0000000B, 1'b1, 2'b00);
    check("fill.ready0", 64'(bus.ready_o), 64'h0);
    cycle("fill.C", 1'b1, 32'h0000000C, 1'b1, 2'b00);
    cycle("fill.D", 1'b1, 32'h0000000D, 1'b1, 2'b00);
`ifdef BSG_FSB_HOP_IN_STALL_CNT_EN
    check("fill.stall2", 64'(stall_cnt), 64'd2);
`endif
    check("fill.headA", 64'(bus.data_o[W-1:0]), 64'h0A);
    cycle("fill.popA", 1'b0, '0, 1'b0, 2'b11);
    check("fill.headB", 64'(bus.data_o[W-1:0]), 64'h0B);
    cycle("fill.popB", 1'b0, '0, 1'b0, 2'b11);
    check("fill.drained", 64'(bus.v_o), 64'h0);

    // Back-to-back streaming with immediate consumption, wrapping pointers.
    for (int i = 0; i < 9; i++) begin
      cycle("b2b", i < 8, 32'hC0DE0000 + 32'(i), 1'b1, exp_v());
      check("b2b.ready", 64'(bus.ready_o), 64'h1);
    end
    cycle("b2b.last", 1'b0, '0, 1'b0, exp_v());
    check("b2b.empty", 64'(bus.v_o), 64'h0);

    // Reset in the middle of buffered traffic.
    cycle("mid.A", 1'b1, 32'h11111111, 1'b1, 2'b00);
    cycle("mid.B", 1'b1, 32'h22222222, 1'b1, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("mid.v_o", 64'(bus.v_o), 64'h0);
    check("mid.ready", 64'(bus.ready_o), 64'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("mid.after", 1'b0, '0, 1'b0, 2'b00);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      y = ($urandom_range(0, 2) == 0) ? exp_v() : (N'($urandom) & exp_v());
      cycle("rand", ($urandom_range(0, 3) != 0), $urandom, (N-1)'($urandom), y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
